// File: rtl/arcade_input_pkg.sv
// Shared definitions for the arcade input mapper: PS/2 scan codes, joystick
// bit positions, key/output state structs and the coin FSM states.
package arcade_input_pkg;

   localparam logic [7:0] KEY_UP       = 8'h75;
   localparam logic [7:0] KEY_DOWN     = 8'h72;
   localparam logic [7:0] KEY_LEFT     = 8'h6B;
   localparam logic [7:0] KEY_RIGHT    = 8'h74;
   localparam logic [7:0] KEY_FIRE_A   = 8'h29;
   localparam logic [7:0] KEY_FIRE_B   = 8'h14;
   localparam logic [7:0] KEY_START1_A = 8'h05;
   localparam logic [7:0] KEY_START1_B = 8'h16;
   localparam logic [7:0] KEY_START2_A = 8'h06;
   localparam logic [7:0] KEY_START2_B = 8'h1E;
   localparam logic [7:0] KEY_COIN_A   = 8'h2E;
   localparam logic [7:0] KEY_COIN_B   = 8'h36;
   localparam logic [7:0] KEY_UP2      = 8'h2D;
   localparam logic [7:0] KEY_DOWN2    = 8'h2B;
   localparam logic [7:0] KEY_LEFT2    = 8'h23;
   localparam logic [7:0] KEY_RIGHT2   = 8'h34;
   localparam logic [7:0] KEY_FIRE2    = 8'h1C;
   localparam logic [7:0] KEY_TEST     = 8'h2C;

   localparam int JOY_RIGHT  = 0;
   localparam int JOY_LEFT   = 1;
   localparam int JOY_DOWN   = 2;
   localparam int JOY_UP     = 3;
   localparam int JOY_FIRE   = 4;
   localparam int JOY_START1 = 5;
   localparam int JOY_START2 = 6;

   typedef enum logic [1:0] {IDLE, PULSE, HOLD} coin_state_e;

   typedef struct packed {
      logic up, down, left, right;
   } dir_t;

   // Keys sharing a function keep separate registers so that releasing one
   // alias does not clear a still-held other alias.
   typedef struct packed {
      logic up, down, left, right;
      logic fire_a, fire_b;
      logic start1_a, start1_b, start2_a, start2_b;
      logic coin_a, coin_b;
      logic up2, down2, left2, right2, fire2;
      logic test;
   } keys_t;

   typedef struct packed {
      dir_t p1;
      logic fire1;
      dir_t p2;
      logic fire2;
      logic start1, start2, test;
   } outs_t;

   function automatic dir_t rotate_dir(input dir_t raw, input logic rot);
      dir_t r;
      r = raw;
      if (rot) begin
         r.up    = raw.left;
         r.down  = raw.right;
         r.left  = raw.down;
         r.right = raw.up;
      end
      return r;
   endfunction

endpackage

// File: rtl/arcade_input_mapper_if.sv
// Input/output bundle of the arcade input mapper: PS/2 event word, joystick
// word and rotation in, player/start/coin/test buttons out.
interface arcade_input_mapper_if;
   logic [10:0] ps2_key;
   logic [15:0] joy;
   logic        rotate;
   logic        up1, down1, left1, right1, fire1;
   logic        up2, down2, left2, right2, fire2;
   logic        start1, start2, coin1, test;

   modport master (
      output ps2_key, joy, rotate,
      input  up1, down1, left1, right1, fire1,
      input  up2, down2, left2, right2, fire2,
      input  start1, start2, coin1, test
   );

   modport slave (
      input  ps2_key, joy, rotate,
      output up1, down1, left1, right1, fire1,
      output up2, down2, left2, right2, fire2,
      output start1, start2, coin1, test
   );
endinterface

// File: rtl/coin_pulser.sv
// Fixed-width, rate-limited coin pulse: rising edge of the request level
// starts a pulse, followed by a holdoff during which requests are dropped.
module coin_pulser
   import arcade_input_pkg::*;
#(
   parameter int COIN_PULSE_CYC   = 120000,
   parameter int COIN_HOLDOFF_CYC = 1200000
) (
   input  logic clk_sys,
   input  logic reset,
   input  logic req_lvl,
   output logic coin1
);

   localparam int CNT_MAX = (COIN_PULSE_CYC > COIN_HOLDOFF_CYC) ? COIN_PULSE_CYC : COIN_HOLDOFF_CYC;
   localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
   localparam logic [CNT_W-1:0] PULSE_LOAD = CNT_W'(COIN_PULSE_CYC - 1);
   localparam logic [CNT_W-1:0] HOLD_LOAD  = CNT_W'(COIN_HOLDOFF_CYC - 1);

   coin_state_e      state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             req_prev_q, coin_q, coin_d;
   logic             req;

   assign req   = req_lvl & ~req_prev_q;
   assign coin1 = coin_q;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      coin_d  = coin_q;
      case (state_q)
         IDLE: if (req) begin
            state_d = PULSE;
            coin_d  = 1'b1;
            cnt_d   = PULSE_LOAD;
         end
         PULSE: if (cnt_q == '0) begin
            state_d = HOLD;
            coin_d  = 1'b0;
            cnt_d   = HOLD_LOAD;
         end else begin
            cnt_d = cnt_q - 1'b1;
         end
         HOLD: if (cnt_q == '0) begin
            state_d = IDLE;
         end else begin
            cnt_d = cnt_q - 1'b1;
         end
         default: begin
            state_d = IDLE;
            coin_d  = 1'b0;
            cnt_d   = '0;
         end
      endcase
   end

   always_ff @(posedge clk_sys) begin
      if (reset) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         coin_q     <= 1'b0;
         req_prev_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         coin_q     <= coin_d;
         req_prev_q <= req_lvl;
      end
   end

endmodule

// File: rtl/arcade_input_mapper.sv
// PS/2 + joystick to game-core button mapper with rotation and coin pulse.
// Optional INPUT_SOCD_CLEAN_EN: cancel opposing directions after rotation.
module arcade_input_mapper
   import arcade_input_pkg::*;
#(
   parameter int COIN_PULSE_CYC   = 120000,
   parameter int COIN_HOLDOFF_CYC = 1200000
) (
   input  logic                  clk_sys,
   input  logic                  reset,
   arcade_input_mapper_if.slave  io
);

   keys_t      key_q, key_d;
   outs_t      out_q, out_d;
   logic       old_toggle_q;
   logic       evt, pressed, ext;
   logic [7:0] code;
   dir_t       raw1, raw2, rot1, rot2;
   logic       coin_req_lvl;

   assign evt     = io.ps2_key[10] != old_toggle_q;
   assign pressed = io.ps2_key[9];
   assign ext     = io.ps2_key[8];
   assign code    = io.ps2_key[7:0];

   // Directions and KEY_FIRE_B accept either extended state; the rest need ext=0.
   always_comb begin
      key_d = key_q;
      if (evt) begin
         case (code)
            KEY_UP:       key_d.up       = pressed;
            KEY_DOWN:     key_d.down     = pressed;
            KEY_LEFT:     key_d.left     = pressed;
            KEY_RIGHT:    key_d.right    = pressed;
            KEY_FIRE_B:   key_d.fire_b   = pressed;
            KEY_FIRE_A:   if (!ext) key_d.fire_a   = pressed;
            KEY_START1_A: if (!ext) key_d.start1_a = pressed;
            KEY_START1_B: if (!ext) key_d.start1_b = pressed;
            KEY_START2_A: if (!ext) key_d.start2_a = pressed;
            KEY_START2_B: if (!ext) key_d.start2_b = pressed;
            KEY_COIN_A:   if (!ext) key_d.coin_a   = pressed;
            KEY_COIN_B:   if (!ext) key_d.coin_b   = pressed;
            KEY_UP2:      if (!ext) key_d.up2      = pressed;
            KEY_DOWN2:    if (!ext) key_d.down2    = pressed;
            KEY_LEFT2:    if (!ext) key_d.left2    = pressed;
            KEY_RIGHT2:   if (!ext) key_d.right2   = pressed;
            KEY_FIRE2:    if (!ext) key_d.fire2    = pressed;
            KEY_TEST:     if (!ext) key_d.test     = pressed;
            default: ;
         endcase
      end
   end

   always_comb begin
      raw1.up    = key_q.up     | io.joy[JOY_UP];
      raw1.down  = key_q.down   | io.joy[JOY_DOWN];
      raw1.left  = key_q.left   | io.joy[JOY_LEFT];
      raw1.right = key_q.right  | io.joy[JOY_RIGHT];
      raw2.up    = key_q.up2    | io.joy[JOY_UP];
      raw2.down  = key_q.down2  | io.joy[JOY_DOWN];
      raw2.left  = key_q.left2  | io.joy[JOY_LEFT];
      raw2.right = key_q.right2 | io.joy[JOY_RIGHT];
      rot1 = rotate_dir(raw1, io.rotate);
      rot2 = rotate_dir(raw2, io.rotate);

      out_d.p1 = rot1;
      out_d.p2 = rot2;
`ifdef INPUT_SOCD_CLEAN_EN
      if (rot1.up & rot1.down) begin
         out_d.p1.up   = 1'b0;
         out_d.p1.down = 1'b0;
      end
      if (rot1.left & rot1.right) begin
         out_d.p1.left  = 1'b0;
         out_d.p1.right = 1'b0;
      end
      if (rot2.up & rot2.down) begin
         out_d.p2.up   = 1'b0;
         out_d.p2.down = 1'b0;
      end
      if (rot2.left & rot2.right) begin
         out_d.p2.left  = 1'b0;
         out_d.p2.right = 1'b0;
      end
`else
`endif
      out_d.fire1  = key_q.fire_a | key_q.fire_b | io.joy[JOY_FIRE];
      out_d.fire2  = key_q.fire2 | io.joy[JOY_FIRE];
      out_d.start1 = key_q.start1_a | key_q.start1_b | io.joy[JOY_START1];
      out_d.start2 = key_q.start2_a | key_q.start2_b | io.joy[JOY_START2];
      out_d.test   = key_q.test;
   end

   // old_toggle tracks the strobe even in reset, so leaving reset never
   // looks like a fresh event.
   always_ff @(posedge clk_sys) begin
      old_toggle_q <= io.ps2_key[10];
      if (reset) begin
         key_q <= '0;
         out_q <= '0;
      end else begin
         key_q <= key_d;
         out_q <= out_d;
      end
   end

   assign coin_req_lvl = key_q.coin_a | key_q.coin_b | out_q.start1 | out_q.start2;

   coin_pulser #(
      .COIN_PULSE_CYC   (COIN_PULSE_CYC),
      .COIN_HOLDOFF_CYC (COIN_HOLDOFF_CYC)
   ) u_coin (
      .clk_sys (clk_sys),
      .reset   (reset),
      .req_lvl (coin_req_lvl),
      .coin1   (io.coin1)
   );

   assign io.up1    = out_q.p1.up;
   assign io.down1  = out_q.p1.down;
   assign io.left1  = out_q.p1.left;
   assign io.right1 = out_q.p1.right;
   assign io.fire1  = out_q.fire1;
   assign io.up2    = out_q.p2.up;
   assign io.down2  = out_q.p2.down;
   assign io.left2  = out_q.p2.left;
   assign io.right2 = out_q.p2.right;
   assign io.fire2  = out_q.fire2;
   assign io.start1 = out_q.start1;
   assign io.start2 = out_q.start2;
   assign io.test   = out_q.test;

endmodule

// File: tb/tb_arcade_input_mapper.sv
// Self-checking bench for arcade_input_mapper (short coin timings).
module tb_arcade_input_mapper;

   logic clk_sys = 1'b0;
   logic reset;
   bit   tog;
   int   checks = 0;
   int   errors = 0;

   arcade_input_mapper_if io();

   arcade_input_mapper #(
      .COIN_PULSE_CYC   (4),
      .COIN_HOLDOFF_CYC (8)
   ) dut (
      .clk_sys (clk_sys),
      .reset   (reset),
      .io      (io)
   );

   always #5 clk_sys = ~clk_sys;

   // {p1 u,d,l,r,fire}_{p2 u,d,l,r,fire}_{start1,start2,test}
   logic [12:0] obs;
   assign obs = {io.up1, io.down1, io.left1, io.right1, io.fire1,
                 io.up2, io.down2, io.left2, io.right2, io.fire2,
                 io.start1, io.start2, io.test};

   typedef struct {
      bit          evt;
      bit          pr;
      bit          ext;
      logic [7:0]  code;
      logic [15:0] joy;
      bit          rot;
      logic [12:0] exp;
   } vec_t;

   vec_t        tbl[$];
   logic [12:0] sb[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic key_evt(input bit pr, input bit ext, input logic [7:0] code);
      tog = ~tog;
      io.ps2_key = {tog, pr, ext, code};
   endtask

   logic [12:0] socd_exp;
   logic [12:0] exp_w;
   bit          exp_c;
   int          bad, rises, highs;
   logic        prev_coin;

   initial begin
`ifdef INPUT_SOCD_CLEAN_EN
      socd_exp = 13'b00000_00100_000;
`else
      socd_exp = 13'b00110_00100_000;
`endif
      //            evt pr ext code    joy       rot exp
      tbl.push_back('{1, 0, 0, 8'h75, 16'h0000, 0, 13'b00000_00000_000});
      tbl.push_back('{1, 1, 0, 8'h29, 16'h0000, 0, 13'b00001_00000_000});
      tbl.push_back('{1, 0, 1, 8'h29, 16'h0000, 0, 13'b00001_00000_000});
      tbl.push_back('{1, 0, 0, 8'h29, 16'h0000, 0, 13'b00000_00000_000});
      tbl.push_back('{1, 1, 1, 8'h14, 16'h0000, 0, 13'b00001_00000_000});
      tbl.push_back('{1, 0, 0, 8'h14, 16'h0000, 0, 13'b00000_00000_000});
      tbl.push_back('{1, 1, 0, 8'h2D, 16'h0000, 0, 13'b00000_10000_000});
      tbl.push_back('{1, 1, 0, 8'h2C, 16'h0000, 0, 13'b00000_10000_001});
      tbl.push_back('{1, 0, 0, 8'h2D, 16'h0000, 0, 13'b00000_00000_001});
      tbl.push_back('{1, 0, 0, 8'h2C, 16'h0000, 0, 13'b00000_00000_000});
      tbl.push_back('{0, 0, 0, 8'h00, 16'h0002, 1, 13'b10000_10000_000});
      tbl.push_back('{0, 0, 0, 8'h00, 16'h0002, 0, 13'b00100_00100_000});
      tbl.push_back('{0, 0, 0, 8'h00, 16'h0010, 0, 13'b00001_00001_000});
      tbl.push_back('{0, 0, 0, 8'h00, 16'h0001, 1, 13'b01000_01000_000});
      tbl.push_back('{0, 0, 0, 8'h00, 16'h0008, 1, 13'b00010_00010_000});
      tbl.push_back('{0, 0, 0, 8'h00, 16'h0004, 1, 13'b00100_00100_000});
      tbl.push_back('{1, 1, 0, 8'h74, 16'h0000, 0, 13'b00010_00000_000});
      tbl.push_back('{0, 0, 0, 8'h00, 16'h0002, 0, socd_exp});
      tbl.push_back('{1, 0, 1, 8'h74, 16'h0000, 0, 13'b00000_00000_000});
      tbl.push_back('{1, 1, 0, 8'h34, 16'h0000, 1, 13'b00000_01000_000});
      tbl.push_back('{1, 0, 0, 8'h34, 16'h0000, 0, 13'b00000_00000_000});
      tbl.push_back('{1, 1, 0, 8'h23, 16'h0000, 0, 13'b00000_00100_000});
      tbl.push_back('{1, 0, 0, 8'h23, 16'h0000, 0, 13'b00000_00000_000});
      tbl.push_back('{1, 1, 0, 8'h2B, 16'h0000, 0, 13'b00000_01000_000});
      tbl.push_back('{1, 0, 0, 8'h2B, 16'h0000, 0, 13'b00000_00000_000});
      tbl.push_back('{1, 1, 0, 8'h1C, 16'h0000, 0, 13'b00000_00001_000});
      tbl.push_back('{1, 0, 0, 8'h1C, 16'h0000, 0, 13'b00000_00000_000});
      tbl.push_back('{1, 1, 1, 8'h72, 16'h0000, 0, 13'b01000_00000_000});
      tbl.push_back('{1, 0, 1, 8'h72, 16'h0000, 0, 13'b00000_00000_000});
      tbl.push_back('{1, 1, 1, 8'h6B, 16'h0000, 0, 13'b00100_00000_000});
      tbl.push_back('{1, 0, 0, 8'h6B, 16'h0000, 0, 13'b00000_00000_000});
      tbl.push_back('{1, 1, 0, 8'h1A, 16'h0000, 0, 13'b00000_00000_000});
      tbl.push_back('{1, 1, 0, 8'h05, 16'h0000, 0, 13'b00000_00000_100});
      tbl.push_back('{1, 1, 0, 8'h16, 16'h0000, 0, 13'b00000_00000_100});
      tbl.push_back('{1, 0, 0, 8'h05, 16'h0000, 0, 13'b00000_00000_100});
      tbl.push_back('{1, 0, 0, 8'h16, 16'h0000, 0, 13'b00000_00000_000});
      tbl.push_back('{1, 1, 0, 8'h1E, 16'h0000, 0, 13'b00000_00000_010});
      tbl.push_back('{1, 0, 0, 8'h1E, 16'h0000, 0, 13'b00000_00000_000});
      tbl.push_back('{1, 1, 0, 8'h06, 16'h0000, 0, 13'b00000_00000_010});
      tbl.push_back('{1, 0, 0, 8'h06, 16'h0000, 0, 13'b00000_00000_000});

      tog = 1'b1;
      io.ps2_key = 11'h400;
      io.joy     = '0;
      io.rotate  = 1'b0;
      reset      = 1'b1;
      repeat (3) @(posedge clk_sys);
      @(negedge clk_sys);
      chk("reset_state", {18'd0, obs, io.coin1}, 32'd0);
      reset = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk_sys);
         chk("quiet_after_reset", {18'd0, obs, io.coin1}, 32'd0);
      end

      // key event needs two edges to reach the output
      @(negedge clk_sys);
      key_evt(1, 1, 8'h75);
      @(posedge clk_sys); #1;
      chk("latency_edge1", {19'd0, obs}, 32'd0);
      @(posedge clk_sys); #1;
      chk("latency_edge2", {19'd0, obs}, {19'd0, 13'b10000_00000_000});

      foreach (tbl[i]) begin
         @(negedge clk_sys);
         if (tbl[i].evt) key_evt(tbl[i].pr, tbl[i].ext, tbl[i].code);
         io.joy    = tbl[i].joy;
         io.rotate = tbl[i].rot;
         sb.push_back(tbl[i].exp);
         @(posedge clk_sys);
         @(posedge clk_sys); #1;
         exp_w = sb.pop_front();
         chk($sformatf("vec%0d", i), {19'd0, obs}, {19'd0, exp_w});
      end
      io.joy = '0;
      io.rotate = 1'b0;
      repeat (20) @(negedge clk_sys);

      // coin pulse width, dropped request during holdoff, accepted after holdoff
      key_evt(1, 0, 8'h2E);
      for (int j = 1; j <= 30; j++) begin
         @(negedge clk_sys);
         exp_c = (j >= 2 && j <= 5) || (j >= 16 && j <= 19);
         chk($sformatf("coin_seq_j%0d", j), {31'd0, io.coin1}, {31'd0, exp_c});
         if (j == 6 || j == 10 || j == 20) key_evt(0, 0, 8'h2E);
         if (j == 8 || j == 14) key_evt(1, 0, 8'h2E);
      end
      repeat (10) @(negedge clk_sys);

      // held start1 from joystick: one pulse, start1 stays high
      bad = 0; rises = 0; highs = 0; prev_coin = 1'b0;
      io.joy = 16'h0020;
      for (int j = 1; j <= 100; j++) begin
         @(negedge clk_sys);
         if (!io.start1) bad++;
         if (io.coin1 && !prev_coin) rises++;
         if (io.coin1) highs++;
         prev_coin = io.coin1;
      end
      chk("held_start1_low_cycles", bad, 0);
      chk("held_start1_pulses", rises, 1);
      chk("held_start1_high_cycles", highs, 4);
      io.joy = '0;
      repeat (20) @(negedge clk_sys);

      // event coinciding with reset is discarded
      reset = 1'b1;
      key_evt(1, 1, 8'h75);
      @(negedge clk_sys);
      reset = 1'b0;
      repeat (3) @(negedge clk_sys);
      chk("event_during_reset", {19'd0, obs}, 32'd0);

      // reset mid-pulse clears coin1 on the next edge
      io.joy = 16'h0040;
      @(negedge clk_sys);
      @(negedge clk_sys);
      chk("pulse_started", {31'd0, io.coin1}, 32'd1);
      reset = 1'b1;
      @(posedge clk_sys); #1;
      chk("reset_mid_pulse", {18'd0, obs, io.coin1}, 32'd0);
      @(negedge clk_sys);
      reset = 1'b0;
      io.joy = '0;
      repeat (3) @(negedge clk_sys);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not complete, expected finish");
      $fatal(1);
   end

endmodule

// File: doc/arcade_input_mapper.md
Name: arcade_input_mapper

Overview:
- Input stage feeding the game core's player/start/coin inputs; replaces the ad-hoc keyboard `always` block in the top level.
- Decodes PS/2 toggle-strobed key events into held button states and merges them with the combined joystick word.
- Applies screen-rotation remapping of directions.
- Generates a fixed-width, rate-limited coin pulse from coin keys and start requests.

Parameters:
- COIN_PULSE_CYC, 120000, coin1 high time in clk_sys cycles (10 ms at 12 MHz); must be >=1.
- COIN_HOLDOFF_CYC, 1200000, low time after a pulse during which new coin requests are dropped; must be >=1.

Ports:
- clk_sys  in  1  system clock
- reset  in  1  synchronous, active-high reset
- ps2_key  in  11  [10] toggles per event, [9] pressed, [8] extended, [7:0] scan code
- joy  in  16  OR of both joysticks: [0] right, [1] left, [2] down, [3] up, [4] fire, [5] start1, [6] start2
- rotate  in  1  1 = horizontal orientation, remap directions
- up1/down1/left1/right1/fire1  out  1 each  player 1 controls
- up2/down2/left2/right2/fire2  out  1 each  player 2 controls
- start1, start2  out  1 each  start buttons
- coin1  out  1  coin pulse
- test  out  1  service/test key held

Behaviour:
- Reset: all key-state registers 0, all outputs 0, coin FSM in IDLE, counter 0; old_toggle is loaded with ps2_key[10], so reset never produces a spurious event.
- Event detect: an event occurs on any cycle where ps2_key[10] != old_toggle; old_toggle <= ps2_key[10] every cycle.
- On an event, the matching key register <= ps2_key[9]. Match on {[8],[7:0]}; X = extended bit ignored:
  - X75 up, X72 down, X6B left, X74 right
  - 029 fire, X14 fire (fire = OR of both key bits)
  - 005 or 016 start1; 006 or 01E start2
  - 02E or 036 coin
  - 02D up2, 02B down2, 023 left2, 034 right2, 01C fire2
  - 02C test
  - Unlisted codes are ignored.
- Raw directions: p1 = key | joy; p2 = key2 | joy (joy feeds both players).
- Rotation when rotate=1: up <= raw left, down <= raw right, left <= raw down, right <= raw up. Applied per player, both players identically.
- fire1 = key fire | joy[4]; fire2 = key fire2 | joy[4]; start1 = keys | joy[5]; start2 = keys | joy[6].
- All outputs are registered.
  - Key event at edge N: key register updates at N; the output reflects it at edge N+1.
  - joy and rotate changes appear one edge later.
- Coin request: rising edge (registered previous value) of (coin key | start1 | start2).
- Coin FSM:
  - IDLE: on request -> PULSE, coin1=1, cnt=COIN_PULSE_CYC-1.
  - PULSE: cnt decrements; at cnt==0 -> HOLD, coin1=0, cnt=COIN_HOLDOFF_CYC-1.
  - HOLD: cnt decrements; at cnt==0 -> IDLE.
  - Requests arriving in PULSE or HOLD are dropped, not queued.
- Counter width is $clog2 of the larger parameter.
- Boundary cases:
  - A press and release in consecutive events updates the register twice; last value wins.
  - An event on the same cycle as reset is discarded.
  - Reset mid-pulse drops coin1 on the next edge.

Optional Feature:
- Macro: INPUT_SOCD_CLEAN_EN.
- Defined: after rotation, per player, if up&down both asserted both outputs are forced 0; same for left&right.
- Undefined: opposing directions pass through unchanged.
- Latency is identical in both builds.

Decomposition:
- Package arcade_input_pkg holds:
  - scan-code localparams (KEY_UP=8'h75 ...)
  - joy bit indices (JOY_RIGHT=0 ... JOY_START2=6)
  - coin FSM enum typedef {IDLE, PULSE, HOLD}
- One sub-module, coin_pulser, contains the request edge detect, FSM and counter, parameterised by COIN_PULSE_CYC and COIN_HOLDOFF_CYC.

Test Plan:
- Reset with ps2_key[10]=1, release reset -> no output changes for 10 cycles.
- Toggle [10] with {pressed=1, ext=1, code=75} -> up1=1 two edges later; toggle again with pressed=0 -> up1=0; other outputs stay 0 throughout.
- rotate=1, joy=16'h0002 (left) -> up1=1, up2=1, left1=0; rotate=0 -> left1=1 after one edge.
- COIN_PULSE_CYC=4, COIN_HOLDOFF_CYC=8, press key 02E -> coin1 high exactly 4 cycles; a second press 3 cycles after coin1 falls is dropped; a press 9 cycles after coin1 falls gives a new 4-cycle pulse.
- Hold joy[5] high for 100 cycles -> exactly one coin pulse and start1=1 for the whole interval.
- INPUT_SOCD_CLEAN_EN build: key right plus joy[1] -> left1=0, right1=0; without the macro -> both 1.
